// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch with one outstanding req/ack, FIFO to decode.
// Optional same-cycle bypass of returned data when the queue is empty: FETCHQ_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [WIDTH-1:0]           imem_addr,
  input  logic                       imem_ack,
  input  logic [WIDTH-1:0]           imem_rdata,
  input  logic                       redirect,
  input  logic [WIDTH-1:0]           redirect_pc,
  input  logic                       stall,
  output logic                       inst_valid,
  output logic [WIDTH-1:0]           inst,
  output logic [WIDTH-1:0]           inst_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] AlignMask = ~WIDTH'(3);
  localparam logic [WIDTH-1:0] ResetPc   = RESET_PC & AlignMask;

  typedef enum logic [1:0] {StRun, StWait, StDiscard} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0]  addr_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [WIDTH-1:0]  inst_mem [DEPTH];
  logic [WIDTH-1:0]  pc4_mem  [DEPTH];

  logic              req_raw;
  logic              ack_hit;
  logic              byp_hit;
  logic              push, pop, flush;
  logic [WIDTH-1:0]  pc_plus4;

  assign pc_plus4 = fetch_pc_q + WIDTH'(4);

  // A slot is reserved before every request, so RUN only asks while the queue has room.
  always_comb begin
    req_raw = 1'b0;
    unique case (state_q)
      StRun:     req_raw = (count_q < CntW'(DEPTH));
      StWait:    req_raw = 1'b1;
      StDiscard: req_raw = 1'b1;
      default:   req_raw = 1'b0;
    endcase
  end

  assign imem_req  = req_raw && !rst;
  assign imem_addr = (state_q == StDiscard) ? addr_q : fetch_pc_q;
  assign ack_hit   = imem_req && imem_ack;

`ifdef FETCHQ_BYPASS_EN
  assign byp_hit = (count_q == '0) && (state_q != StDiscard) && ack_hit && !redirect && !rst;
`else
  assign byp_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    if (redirect) begin
      flush      = 1'b1;
      fetch_pc_d = redirect_pc & AlignMask;
      // An unacked request must still finish its handshake; its data is then dropped.
      if (ack_hit) begin
        state_d = StRun;
      end else if (imem_req) begin
        state_d = StDiscard;
      end else begin
        state_d = StRun;
      end
    end else begin
      pop = (count_q != '0) && !stall;
      unique case (state_q)
        StRun: begin
          if (imem_req) begin
            if (imem_ack) begin
              push       = !(byp_hit && !stall);
              fetch_pc_d = pc_plus4;
            end else begin
              state_d = StWait;
            end
          end
        end
        StWait: begin
          if (imem_ack) begin
            push       = !(byp_hit && !stall);
            fetch_pc_d = pc_plus4;
            state_d    = StRun;
          end
        end
        StDiscard: begin
          if (imem_ack) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      fetch_pc_q <= ResetPc;
      addr_q     <= ResetPc;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      // Tracks the presented address so DISCARD can keep the old one after fetch_pc moves.
      addr_q     <= imem_addr;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= imem_rdata;
      pc4_mem[wr_ptr_q]  <= pc_plus4;
    end
  end

  always_comb begin
    inst_valid    = 1'b0;
    inst          = '0;
    inst_pc_plus4 = '0;
    if (byp_hit) begin
      inst_valid    = 1'b1;
      inst          = imem_rdata;
      inst_pc_plus4 = pc_plus4;
    end else if (count_q != '0) begin
      inst_valid    = 1'b1;
      inst          = inst_mem[rd_ptr_q];
      inst_pc_plus4 = pc4_mem[rd_ptr_q];
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model, directed cases, random run.
module tb_fetch_queue;

  localparam int Depth = 4;
`ifdef FETCHQ_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc_plus4;
  logic [2:0]  count;

  fetch_queue #(.WIDTH(32), .DEPTH(Depth), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stall        (stall),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc_plus4(inst_pc_plus4),
    .count        (count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of delivered words plus the one in-flight request.
  logic [31:0] mq_inst[$];
  logic [31:0] mq_pc4[$];
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_disc;
  logic [31:0] m_out_addr;
  bit          cur_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    mq_inst.delete();
    mq_pc4.delete();
    m_pc   = 32'h0;
    m_out  = 1'b0;
    m_disc = 1'b0;
    m_out_addr = 32'h0;
  endfunction

  function automatic logic [31:0] model_addr();
    return m_out ? m_out_addr : m_pc;
  endfunction

  task automatic compare();
    bit          e_req, byp, e_valid;
    logic [31:0] e_inst, e_pc4;
    int          n;
    n      = mq_inst.size();
    e_req  = !rst && (m_out || n < Depth);
    byp    = Bypass && !rst && n == 0 && !(m_out && m_disc) && imem_ack && e_req && !redirect;
    e_valid = byp || n != 0;
    e_inst = byp ? imem_rdata : (n != 0 ? mq_inst[0] : 32'h0);
    e_pc4  = byp ? m_pc + 32'd4 : (n != 0 ? mq_pc4[0] : 32'h0);
    chk("imem_req", {31'h0, imem_req}, {31'h0, e_req});
    chk("imem_addr", imem_addr, model_addr());
    chk("count", {29'h0, count}, n);
    chk("inst_valid", {31'h0, inst_valid}, {31'h0, e_valid});
    chk("inst", inst, e_inst);
    chk("inst_pc_plus4", inst_pc_plus4, e_pc4);
  endtask

  function automatic void model_update();
    int          n0;
    bit          do_pop;
    logic [31:0] a;
    n0 = mq_inst.size();
    a  = model_addr();
    if (redirect) begin
      mq_inst.delete();
      mq_pc4.delete();
      if (imem_ack) begin
        m_out = 1'b0;
      end else if (cur_req) begin
        if (!m_out) m_out_addr = m_pc;
        m_out  = 1'b1;
        m_disc = 1'b1;
      end
      m_pc = redirect_pc & ~32'd3;
    end else begin
      do_pop = n0 > 0 && !stall;
      if (imem_ack) begin
        if (!(m_out && m_disc)) begin
          if (!(Bypass && n0 == 0 && !stall)) begin
            mq_inst.push_back(imem_rdata);
            mq_pc4.push_back(a + 32'd4);
          end
          m_pc = m_pc + 32'd4;
        end
        m_out = 1'b0;
      end else if (cur_req && !m_out) begin
        m_out      = 1'b1;
        m_out_addr = m_pc;
        m_disc     = 1'b0;
      end
      if (do_pop) begin
        void'(mq_inst.pop_front());
        void'(mq_pc4.pop_front());
      end
    end
  endfunction

  // Inputs change on the falling edge; outputs are compared 1 time unit later.
  task automatic drive(input bit ack_en, input bit redir, input logic [31:0] rpc,
                       input bit stl, input logic [31:0] data);
    @(negedge clk);
    cur_req     = !rst && (m_out || mq_inst.size() < Depth);
    redirect    = redir;
    redirect_pc = rpc;
    stall       = stl;
    imem_rdata  = data;
    imem_ack    = ack_en && cur_req;
    #1;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else model_update();
  endtask

  task automatic step(input bit ack_en, input bit redir, input logic [31:0] rpc,
                      input bit stl, input logic [31:0] data);
    drive(ack_en, redir, rpc, stl, data);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    step(1'b0, 1'b0, 32'h0, 1'b0, $urandom);
    step(1'b0, 1'b0, 32'h0, 1'b0, $urandom);
    #2 rst = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    model_clear();

    // Reset state
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_count", {29'h0, count}, 32'h0);
    tick();
    #2 rst = 1'b0;

    // Zero-wait streaming, no stall
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, $urandom);
      chk("stream_addr", imem_addr, 32'(4 * (k - 1)));
      if (k >= 2) chk("stream_pc4", inst_pc_plus4, Bypass ? 32'(4 * k) : 32'(4 * (k - 1)));
      chk("stream_valid", {31'h0, inst_valid}, {31'h0, (k >= 2) || Bypass});
      tick();
    end

    // Stall fills queue, release drains in order
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
    drive(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
    chk("full_count", {29'h0, count}, 32'd4);
    chk("full_req", {31'h0, imem_req}, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, $urandom);
    chk("drain_pc4_0", inst_pc_plus4, 32'd4);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, $urandom);
    chk("resume_addr", imem_addr, 32'h10);
    chk("drain_pc4_1", inst_pc_plus4, 32'd8);
    tick();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'h0, 1'b0, $urandom);

    // Redirect while a late request is outstanding
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
    step(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
    drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
    chk("late_addr", imem_addr, 32'h8);
    tick();
    step(1'b0, 1'b1, 32'h103, 1'b1, $urandom);
    drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
    chk("discard_addr0", imem_addr, 32'h8);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
    chk("discard_addr1", imem_addr, 32'h8);
    tick();
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, $urandom);
      if (i == 0) chk("retarget_addr", imem_addr, 32'h100);
      if (inst_valid) begin
        found = 1'b1;
        chk("retarget_pc4", inst_pc_plus4, 32'h104);
      end
      tick();
    end
    chk("retarget_seen", {31'h0, found}, 32'h1);

    // Redirect coinciding with ack at count 2
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
    step(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
    drive(1'b1, 1'b1, 32'h200, 1'b1, $urandom);
    chk("redir_ack_count_before", {29'h0, count}, 32'd2);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
    chk("redir_ack_count_after", {29'h0, count}, 32'd0);
    chk("redir_ack_addr", imem_addr, 32'h200);
    tick();

    // Asynchronous reset while waiting with three entries queued
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
    step(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
    drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
    chk("wait_count", {29'h0, count}, 32'd3);
    chk("wait_req", {31'h0, imem_req}, 32'h1);
    #1 rst = 1'b1;
    model_clear();
    #1;
    chk("arst_req", {31'h0, imem_req}, 32'h0);
    chk("arst_valid", {31'h0, inst_valid}, 32'h0);
    chk("arst_count", {29'h0, count}, 32'h0);
    tick();
    #2 rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, $urandom);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_req_after", {31'h0, imem_req}, 32'h1);
    tick();

    // Empty-queue delivery, without and with stall
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h00500093);
    chk("byp_valid", {31'h0, inst_valid}, {31'h0, Bypass});
    chk("byp_inst", inst, Bypass ? 32'h00500093 : 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
    chk("byp_count", {29'h0, count}, Bypass ? 32'd0 : 32'd1);
    tick();
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h00500093);
    chk("byp_stall_inst", inst, Bypass ? 32'h00500093 : 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
    chk("byp_stall_count", {29'h0, count}, 32'd1);
    tick();

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom,
           $urandom_range(0, 2) == 0, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch stage between a variable-latency instruction memory and the IF/ID pipeline register of the 5-stage RISC-V core.
- Generates sequential fetch addresses and runs a req/ack handshake with the memory, one request outstanding at a time.
- Buffers returned instructions with their PC+4 in a small FIFO.
- Decode drains the FIFO; branch/jump redirects flush it and restart fetch.

Parameters:
- WIDTH, 32, instruction/address width.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- RESET_PC, 32'h0, first fetch address after reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  WIDTH  fetch address, bits [1:0] always 0.
- imem_ack  in  1  memory accepts request and returns data this cycle.
- imem_rdata  in  WIDTH  instruction word, valid when imem_ack=1.
- redirect  in  1  taken branch/jump; flush and refetch.
- redirect_pc  in  WIDTH  new fetch address; bits [1:0] ignored (forced 0).
- stall  in  1  decode not accepting (StallD).
- inst_valid  out  1  inst/inst_pc_plus4 hold a valid entry.
- inst  out  WIDTH  head-of-queue instruction.
- inst_pc_plus4  out  WIDTH  PC+4 of the head instruction.
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset: fetch_pc=RESET_PC, FSM=RUN, FIFO empty, count=0. Outputs imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc_plus4=0.
- imem_req may first rise in the cycle after rst deasserts.
- State is registered; outputs are combinational from state only, except under FETCHQ_BYPASS_EN.
- FSM states: RUN, WAIT, DISCARD.
- RUN: imem_req=1 when (count + pending) < DEPTH, where pending = 1 in WAIT and 0 otherwise. imem_addr=fetch_pc.
  - ack=1: push {imem_rdata, fetch_pc+4}, fetch_pc += 4, stay in RUN. Back-to-back requests are allowed (throughput 1/cycle).
  - ack=0 with req=1: go to WAIT.
- WAIT: imem_req=1 and imem_addr held stable until ack. On ack: push, fetch_pc += 4, return to RUN.
- DISCARD: the request issued before a redirect is still outstanding. imem_req=1 with the OLD address held stable, as the handshake must complete. On ack: drop the data, go to RUN. fetch_pc already holds the redirect target.
- Space rule: a request is never issued unless a FIFO slot is reserved, so a push never overflows.
- Pop: occurs when inst_valid && !stall. Push and pop in the same cycle is allowed at any occupancy; count is unchanged.
- Redirect has priority over all other events:
  - FIFO cleared, count=0, fetch_pc=redirect_pc, any same-cycle push/pop is suppressed.
  - If the FSM is in WAIT, or in RUN with req=1 and ack=0: go to DISCARD.
  - If ack=1 in the redirect cycle: data dropped, go to RUN.
  - Redirect while in DISCARD: retarget fetch_pc, stay in DISCARD.
- inst_valid = (count != 0). inst and inst_pc_plus4 show the head entry, or 0 when empty.
- Pointers wrap modulo DEPTH. fetch_pc wraps modulo 2^WIDTH.
- rst asserted mid-operation: all state clears immediately (asynchronously), imem_req drops in the same cycle. Any memory transaction in flight is abandoned; the memory side is reset by the same rst.

Optional Feature:
- Macro: FETCHQ_BYPASS_EN.
- Defined: when the FIFO is empty, FSM in RUN/WAIT, ack=1, no redirect and no rst, the data is presented combinationally in the same cycle: inst=imem_rdata, inst_pc_plus4=fetch_pc+4, inst_valid=1.
  - If stall=0, the word is consumed and not pushed.
  - If stall=1, it is pushed normally.
  - Fetch-to-decode latency drops from 1 cycle to 0 cycles.
- Undefined: the data is always pushed and becomes visible the cycle after ack.

Test Plan:
- Zero-wait memory (ack=1 whenever req=1), stall=0, RESET_PC=0 -> imem_addr=0,4,8,12 on consecutive cycles. inst_valid=1 from the cycle after the first ack. inst_pc_plus4=4,8,12,16 in order, with no bubbles.
- stall=1 held, zero-wait memory -> exactly 4 requests issued, count=4, imem_req=0. Release stall -> 4 entries pop in order, fetch resumes at 0x10.
- Request to 0x8 acked 3 cycles late; redirect to 0x103 one cycle after issue -> imem_addr stays 0x8 until ack, that data is dropped. Next imem_addr=0x100; the first valid output has inst_pc_plus4=0x104.
- Redirect to 0x200 coinciding with ack and with count=2 -> count=0 next cycle, the acked data is not pushed, next imem_addr=0x200.
- rst pulsed while in WAIT with count=3 -> imem_req=0, inst_valid=0, count=0 immediately. After release the first imem_addr=RESET_PC.
- FETCHQ_BYPASS_EN defined, FIFO empty, ack with rdata=0x00500093, stall=0 -> inst=0x00500093 and inst_valid=1 in the ack cycle, count stays 0. Repeat with stall=1 -> count=1 next cycle.
